// File: rtl/gfx_seq_pkg.sv
// Shared types and constants for the graphics frame sequencer.
//   tri_w_of    : address width needed for a triangle memory of a given depth
//   seq_state_t : frame sequencer states
//   tri_entry_t : one prefetched triangle (id plus its three vertices)
package gfx_seq_pkg;

   function automatic int tri_w_of(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int GFX_P_WIDTH = 16;
   localparam int GFX_NUM_TRI = 2048;
   localparam int GFX_TRI_W   = tri_w_of(GFX_NUM_TRI);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} seq_state_t;

   typedef struct packed {
      logic [GFX_TRI_W-1:0]     tri_id;
      logic [9*GFX_P_WIDTH-1:0] P;
   } tri_entry_t;

endpackage

// File: rtl/tri_prefetch_fifo.sv
// Show-ahead prefetch FIFO of triangle entries. The head entry is visible
// without a read strobe; pop advances past it.
//   clk_in, rst_in : clock, synchronous active-high reset
//   push, push_entry : write an entry (ignored when full)
//   pop            : discard the head entry (ignored when empty)
//   head           : current oldest entry (undefined content when empty)
//   count, empty   : occupancy
module tri_prefetch_fifo
   import gfx_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push,
   input  tri_entry_t             push_entry,
   input  logic                   pop,
   output tri_entry_t             head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   tri_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (count != FULL_COUNT);
   assign head    = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/graphics_frame_sequencer.sv
// Per-frame controller for the triangle pipeline: snapshots the camera on a
// frame start, streams triangle ids 0..count-1 from a fixed-latency BROM
// through a credit-limited prefetch FIFO, waits for the rasterizer to go
// quiet, then pulses frame_done.
//   clk_in, rst_in            : clock, synchronous active-high reset
//   frame_start_in, num_tri_in, cam_*_in : frame request and its parameters
//   tri_addr_out, tri_rd_en_out, tri_data_in : triangle BROM interface
//   gp_valid_out, gp_ready_in, gp_tri_id_out, gp_P_out, gp_*_out : pipeline feed
//   gp_pix_valid_in           : pipeline pixel activity (drain detection)
//   busy_out, frame_done_out, tri_accepted_out : frame status
module graphics_frame_sequencer
   import gfx_seq_pkg::*;
#(
   parameter int  P_WIDTH      = GFX_P_WIDTH,
   parameter int  C_WIDTH      = 18,
   parameter int  V_WIDTH      = 16,
   parameter int  NUM_TRI      = GFX_NUM_TRI,
   parameter int  BROM_LATENCY = 2,
   parameter int  FIFO_DEPTH   = 4,
   parameter int  DRAIN_IDLE   = 8,
   localparam int TRI_W        = tri_w_of(NUM_TRI)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   frame_start_in,
   input  logic [TRI_W:0]         num_tri_in,
   input  logic [3*C_WIDTH-1:0]   cam_C_in,
   input  logic [3*V_WIDTH-1:0]   cam_u_in,
   input  logic [3*V_WIDTH-1:0]   cam_v_in,
   input  logic [3*V_WIDTH-1:0]   cam_n_in,
   output logic [TRI_W-1:0]       tri_addr_out,
   output logic                   tri_rd_en_out,
   input  logic [9*P_WIDTH-1:0]   tri_data_in,
   output logic                   gp_valid_out,
   input  logic                   gp_ready_in,
   output logic [TRI_W-1:0]       gp_tri_id_out,
   output logic [9*P_WIDTH-1:0]   gp_P_out,
   output logic [3*C_WIDTH-1:0]   gp_C_out,
   output logic [3*V_WIDTH-1:0]   gp_u_out,
   output logic [3*V_WIDTH-1:0]   gp_v_out,
   output logic [3*V_WIDTH-1:0]   gp_n_out,
   input  logic                   gp_pix_valid_in,
   output logic                   busy_out,
   output logic                   frame_done_out,
   output logic [TRI_W:0]         tri_accepted_out
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_FETCH = FETCH;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   localparam int             FCW       = $clog2(FIFO_DEPTH) + 1;
   localparam int             IW        = $clog2(DRAIN_IDLE + 1);
   localparam logic [TRI_W:0] MAX_TRI   = (TRI_W+1)'(NUM_TRI);
   localparam logic [IW-1:0]  IDLE_LAST = IW'(DRAIN_IDLE - 1);

   logic [1:0]              state;
   logic [TRI_W:0]          tri_count;
   logic [TRI_W:0]          issued;
   logic [TRI_W:0]          accepted;
   logic [IW-1:0]           idle_cnt;
   logic [BROM_LATENCY-1:0] rd_pipe;
   logic [TRI_W-1:0]        id_pipe [BROM_LATENCY];
   tri_entry_t              push_entry;
   tri_entry_t              fifo_head;
   logic [FCW-1:0]          fifo_count;
   logic                    fifo_empty;
   logic                    issue;
   logic                    xfer;
   int                      occupancy;

   // A read may only issue if its data is guaranteed a FIFO slot on return:
   // reads in flight plus entries already queued must leave room.
   always_comb begin
      occupancy = int'(fifo_count);
      for (int i = 0; i < BROM_LATENCY; i++) begin
         occupancy = occupancy + int'(rd_pipe[i]);
      end
      issue = (state == ST_FETCH) && (issued < tri_count) && (occupancy < FIFO_DEPTH);
   end

   assign xfer             = gp_valid_out && gp_ready_in;
   assign tri_rd_en_out    = issue;
   assign tri_addr_out     = issue ? issued[TRI_W-1:0] : '0;
   assign gp_valid_out     = !fifo_empty;
   assign gp_tri_id_out    = fifo_empty ? '0 : fifo_head.tri_id;
   assign gp_P_out         = fifo_empty ? '0 : fifo_head.P;
   assign tri_accepted_out = accepted;
   assign push_entry       = '{tri_id: id_pipe[BROM_LATENCY-1], P: tri_data_in};

   // Read-latency tracker: the strobe and its id travel alongside the BROM
   // so the returning data can be tagged and pushed in the right cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_pipe <= '0;
         for (int i = 0; i < BROM_LATENCY; i++) begin
            id_pipe[i] <= '0;
         end
      end else begin
         rd_pipe[0] <= issue;
         id_pipe[0] <= issued[TRI_W-1:0];
         for (int i = 1; i < BROM_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            id_pipe[i] <= id_pipe[i-1];
         end
      end
   end

   tri_prefetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .push       (rd_pipe[BROM_LATENCY-1]),
      .push_entry (push_entry),
      .pop        (xfer),
      .head       (fifo_head),
      .count      (fifo_count),
      .empty      (fifo_empty)
   );

   // Frame control. The drain exit fires on the quiet cycle that brings the
   // idle run to DRAIN_IDLE, so frame_done appears on the following cycle
   // together with the DONE state.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= ST_IDLE;
         tri_count      <= '0;
         issued         <= '0;
         accepted       <= '0;
         idle_cnt       <= '0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
         gp_C_out       <= '0;
         gp_u_out       <= '0;
         gp_v_out       <= '0;
         gp_n_out       <= '0;
      end else begin
         frame_done_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (frame_start_in) begin
                  gp_C_out  <= cam_C_in;
                  gp_u_out  <= cam_u_in;
                  gp_v_out  <= cam_v_in;
                  gp_n_out  <= cam_n_in;
                  tri_count <= (num_tri_in > MAX_TRI) ? MAX_TRI : num_tri_in;
                  issued    <= '0;
                  accepted  <= '0;
                  busy_out  <= 1'b1;
                  state     <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (issue) issued <= issued + 1'b1;
               if (xfer)  accepted <= accepted + 1'b1;
               if (accepted == tri_count) begin
                  idle_cnt <= '0;
                  state    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (gp_ready_in && !gp_pix_valid_in) begin
                  if (idle_cnt == IDLE_LAST) begin
                     frame_done_out <= 1'b1;
                     busy_out       <= 1'b0;
                     state          <= ST_DONE;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end else begin
                  idle_cnt <= '0;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_graphics_frame_sequencer.sv
// Randomized self-checking bench for graphics_frame_sequencer. A behavioural
// BROM supplies a unique vertex pattern per address; a frame-level model
// predicts ids, data, read addresses, credit limits and the drain timing.
module tb_graphics_frame_sequencer;

   localparam int P_WIDTH      = 16;
   localparam int C_WIDTH      = 18;
   localparam int V_WIDTH      = 16;
   localparam int NUM_TRI      = 2048;
   localparam int TRI_W        = 11;
   localparam int NW           = TRI_W + 1;
   localparam int BROM_LATENCY = 2;
   localparam int FIFO_DEPTH   = 4;
   localparam int DRAIN_IDLE   = 8;
   localparam int PW           = 9 * P_WIDTH;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 frame_start_in;
   logic [NW-1:0]        num_tri_in;
   logic [3*C_WIDTH-1:0] cam_C_in;
   logic [3*V_WIDTH-1:0] cam_u_in, cam_v_in, cam_n_in;
   logic [TRI_W-1:0]     tri_addr_out;
   logic                 tri_rd_en_out;
   logic [PW-1:0]        tri_data_in;
   logic                 gp_valid_out;
   logic                 gp_ready_in;
   logic [TRI_W-1:0]     gp_tri_id_out;
   logic [PW-1:0]        gp_P_out;
   logic [3*C_WIDTH-1:0] gp_C_out;
   logic [3*V_WIDTH-1:0] gp_u_out, gp_v_out, gp_n_out;
   logic                 gp_pix_valid_in;
   logic                 busy_out;
   logic                 frame_done_out;
   logic [NW-1:0]        tri_accepted_out;

   always #5 clk_in = ~clk_in;

   graphics_frame_sequencer #(
      .P_WIDTH(P_WIDTH), .C_WIDTH(C_WIDTH), .V_WIDTH(V_WIDTH), .NUM_TRI(NUM_TRI),
      .BROM_LATENCY(BROM_LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .DRAIN_IDLE(DRAIN_IDLE)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
      .num_tri_in(num_tri_in), .cam_C_in(cam_C_in), .cam_u_in(cam_u_in),
      .cam_v_in(cam_v_in), .cam_n_in(cam_n_in), .tri_addr_out(tri_addr_out),
      .tri_rd_en_out(tri_rd_en_out), .tri_data_in(tri_data_in),
      .gp_valid_out(gp_valid_out), .gp_ready_in(gp_ready_in),
      .gp_tri_id_out(gp_tri_id_out), .gp_P_out(gp_P_out), .gp_C_out(gp_C_out),
      .gp_u_out(gp_u_out), .gp_v_out(gp_v_out), .gp_n_out(gp_n_out),
      .gp_pix_valid_in(gp_pix_valid_in), .busy_out(busy_out),
      .frame_done_out(frame_done_out), .tri_accepted_out(tri_accepted_out)
   );

   function automatic logic [PW-1:0] brom_pattern(input int id);
      logic [PW-1:0] r;
      for (int k = 0; k < 9; k++) begin
         r[k*P_WIDTH +: P_WIDTH] = P_WIDTH'(id * (k + 3) + k * 4919) ^ P_WIDTH'(16'h5A3C);
      end
      return r;
   endfunction

   // Behavioural BROM: strobe sampled mid-cycle, data appears BROM_LATENCY
   // cycles later; outside that window the bus carries junk.
   logic          rd_q;
   logic [TRI_W-1:0] addr_q;
   logic [PW-1:0] brom_stage [BROM_LATENCY];

   always @(negedge clk_in) begin
      rd_q   <= tri_rd_en_out;
      addr_q <= tri_addr_out;
   end

   always @(posedge clk_in) begin
      brom_stage[0] <= rd_q ? brom_pattern(int'(addr_q))
                            : PW'({$urandom, $urandom, $urandom, $urandom, $urandom});
      for (int i = 1; i < BROM_LATENCY; i++) brom_stage[i] <= brom_stage[i-1];
   end
   assign tri_data_in = brom_stage[BROM_LATENCY-1];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int frames_done = 0;
   int exp_count, acc_seen, rd_seen, start_cyc, drain_from, quiet_run, idle_from;
   bit frame_active = 0;
   bit post_reset = 0;
   bit prev_stall = 0;
   logic [TRI_W-1:0]     prev_id;
   logic [PW-1:0]        prev_P;
   logic [3*C_WIDTH-1:0] exp_C;
   logic [3*V_WIDTH-1:0] exp_u, exp_v, exp_n;
   int ready_mode = 0;
   int pix_mode = 0;
   bit noise = 0;

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Frame-level reference model, evaluated mid-cycle.
   task automatic checkCycle();
      bit quiet, xfer, exp_done;
      if (rst_in) begin
         frame_active = 0;
         post_reset   = 1;
         prev_stall   = 0;
         idle_from    = cyc + 1;
         return;
      end
      if (post_reset) begin
         checkOutput("rst_ctrl", 256'({tri_addr_out, tri_rd_en_out, gp_valid_out, gp_tri_id_out,
                                      busy_out, frame_done_out, tri_accepted_out}), 256'(0));
         checkOutput("rst_P", 256'(gp_P_out), 256'(0));
         checkOutput("rst_C", 256'(gp_C_out), 256'(0));
         checkOutput("rst_uvn", 256'({gp_u_out, gp_v_out, gp_n_out}), 256'(0));
         post_reset = 0;
      end
      quiet    = gp_ready_in && !gp_pix_valid_in;
      xfer     = gp_valid_out && gp_ready_in;
      exp_done = frame_active && (quiet_run == DRAIN_IDLE);
      checkOutput("frame_done", 256'(frame_done_out), 256'(exp_done));
      checkOutput("busy", 256'(busy_out), 256'(frame_active && !exp_done));
      if (!frame_active) begin
         if (gp_valid_out || tri_rd_en_out)
            checkOutput("idle_activity", 256'({gp_valid_out, tri_rd_en_out}), 256'(0));
      end else begin
         if (tri_rd_en_out) begin
            checkOutput("rd_addr", 256'(tri_addr_out), 256'(rd_seen));
            checkOutput("rd_in_range", 256'(rd_seen < exp_count), 256'(1));
            checkOutput("rd_credit", 256'((rd_seen - acc_seen) < FIFO_DEPTH), 256'(1));
            if (rd_seen == 0) checkOutput("first_rd_latency", 256'(cyc - start_cyc), 256'(1));
            rd_seen++;
         end
         if (prev_stall) begin
            checkOutput("hold_valid", 256'(gp_valid_out), 256'(1));
            checkOutput("hold_id", 256'(gp_tri_id_out), 256'(prev_id));
            checkOutput("hold_P", 256'(gp_P_out), 256'(prev_P));
         end
         if (xfer) begin
            checkOutput("xfer_in_frame", 256'(acc_seen < exp_count), 256'(1));
            checkOutput("xfer_id", 256'(gp_tri_id_out), 256'(acc_seen));
            checkOutput("xfer_P", 256'(gp_P_out), 256'(brom_pattern(acc_seen)));
            if (ready_mode == 0)
               checkOutput("stream_timing", 256'(cyc - start_cyc), 256'(2 + BROM_LATENCY + acc_seen));
            acc_seen++;
            if (acc_seen == exp_count) drain_from = cyc + 2;
         end
         prev_stall = gp_valid_out && !gp_ready_in;
         prev_id    = gp_tri_id_out;
         prev_P     = gp_P_out;
         if (exp_done) begin
            checkOutput("acc_count", 256'(acc_seen), 256'(exp_count));
            checkOutput("rd_count", 256'(rd_seen), 256'(exp_count));
            checkOutput("tri_accepted", 256'(tri_accepted_out), 256'(exp_count));
            checkOutput("cam_C", 256'(gp_C_out), 256'(exp_C));
            checkOutput("cam_uvn", 256'({gp_u_out, gp_v_out, gp_n_out}), 256'({exp_u, exp_v, exp_n}));
            if (exp_count == 0 && ready_mode == 0 && pix_mode == 0)
               checkOutput("empty_done_latency", 256'(cyc - start_cyc), 256'(DRAIN_IDLE + 2));
            frame_active = 0;
            frames_done++;
            idle_from  = cyc + 1;
            quiet_run  = 0;
            prev_stall = 0;
         end else if (cyc >= drain_from) begin
            quiet_run = quiet ? quiet_run + 1 : 0;
         end
      end
      if (frame_start_in && !frame_active && cyc >= idle_from) begin
         frame_active = 1;
         start_cyc    = cyc;
         exp_count    = (int'(num_tri_in) > NUM_TRI) ? NUM_TRI : int'(num_tri_in);
         acc_seen     = 0;
         rd_seen      = 0;
         quiet_run    = 0;
         prev_stall   = 0;
         drain_from   = (exp_count == 0) ? cyc + 2 : 32'h3fff_ffff;
         exp_C = cam_C_in;
         exp_u = cam_u_in;
         exp_v = cam_v_in;
         exp_n = cam_n_in;
      end
   endtask

   task automatic applyStimulus(input bit start, input int num, input bit rst);
      @(posedge clk_in);
      #1;
      cyc++;
      rst_in         = rst;
      frame_start_in = start || (noise && frame_active && ($urandom_range(0, 7) == 0));
      num_tri_in     = start ? NW'(num) : NW'($urandom);
      cam_C_in       = (3*C_WIDTH)'({$urandom, $urandom});
      cam_u_in       = (3*V_WIDTH)'({$urandom, $urandom});
      cam_v_in       = (3*V_WIDTH)'({$urandom, $urandom});
      cam_n_in       = (3*V_WIDTH)'({$urandom, $urandom});
      case (ready_mode)
         1:       gp_ready_in = !(frame_active && (cyc - start_cyc >= 5) && (cyc - start_cyc <= 14));
         2:       gp_ready_in = ($urandom_range(0, 7) != 0);
         default: gp_ready_in = 1'b1;
      endcase
      gp_pix_valid_in = (pix_mode != 0) && ($urandom_range(0, 7) == 0);
      @(negedge clk_in);
      checkCycle();
   endtask

   task automatic runFrame(input int num, input int rmode, input int pmode, input bit nz);
      int target;
      target     = frames_done + 1;
      ready_mode = rmode;
      pix_mode   = pmode;
      noise      = nz;
      applyStimulus(1'b1, num, 1'b0);
      for (int i = 0; i < 6000 && frames_done < target; i++) applyStimulus(1'b0, 0, 1'b0);
      if (frames_done < target) checkOutput("frame_timeout", 256'(frames_done), 256'(target));
   endtask

   initial begin
      rst_in          = 1'b1;
      frame_start_in  = 1'b0;
      num_tri_in      = '0;
      cam_C_in        = '0;
      cam_u_in        = '0;
      cam_v_in        = '0;
      cam_n_in        = '0;
      gp_ready_in     = 1'b1;
      gp_pix_valid_in = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0);

      runFrame(3, 0, 0, 1'b0);
      runFrame(20, 1, 0, 1'b0);
      runFrame(0, 0, 0, 1'b0);
      runFrame(15, 2, 1, 1'b1);
      runFrame(2049, 0, 0, 1'b0);
      runFrame(5, 0, 0, 1'b0);

      ready_mode = 2;
      pix_mode   = 0;
      noise      = 1'b0;
      applyStimulus(1'b1, 20, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1);
      runFrame(2, 0, 0, 1'b0);

      for (int f = 0; f < 6; f++) runFrame($urandom_range(0, 40), 2, 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
